// File: rtl/layer2_bias_argmax.sv
// Layer-2 bias add and argmax: walks the snapshotted accumulators one element per cycle.
// Define LAYER2_SATURATE_EN to clamp out-of-range sums instead of wrapping them.
module layer2_bias_argmax #(
    parameter int OUT_SIZE = 10,
    parameter int W        = 8,
    parameter int ACC_W    = 20,
    parameter int IDX_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [OUT_SIZE*W-1:0]     bias_in,
    input  logic [OUT_SIZE*ACC_W-1:0] acc_in,
    output logic [OUT_SIZE*ACC_W-1:0] logits_out,
    output logic [IDX_W-1:0]          class_idx,
    output logic [ACC_W-1:0]          max_val,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t                    state_q, state_d;
    logic [OUT_SIZE*W-1:0]     bias_q;
    logic [OUT_SIZE*ACC_W-1:0] acc_q;
    logic [IDX_W-1:0]          k_q;
    logic [ACC_W-1:0]          sum_red;
    logic                      last_elem;
    logic                      new_max;

    // The snapshots shift down each ADD cycle, so element k always sits in the low slot.
`ifdef LAYER2_SATURATE_EN
    logic [ACC_W:0] sum_ext;

    assign sum_ext = {acc_q[ACC_W-1], acc_q[ACC_W-1:0]}
                   + {{(ACC_W+1-W){bias_q[W-1]}}, bias_q[W-1:0]};

    always_comb begin
        sum_red = sum_ext[ACC_W-1:0];
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
            sum_red = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign sum_red = acc_q[ACC_W-1:0] + {{(ACC_W-W){bias_q[W-1]}}, bias_q[W-1:0]};
`endif

    assign last_elem = (k_q == IDX_W'(OUT_SIZE-1));
    assign new_max   = (k_q == '0) || ($signed(sum_red) > $signed(max_val));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (last_elem) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Results persist after DONE until the next pass overwrites them element by element.
    always_ff @(posedge clk) begin
        if (rst) begin
            bias_q     <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            logits_out <= '0;
            class_idx  <= '0;
            max_val    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bias_q <= bias_in;
                        acc_q  <= acc_in;
                        k_q    <= '0;
                    end
                end
                ADD: begin
                    logits_out[k_q*ACC_W +: ACC_W] <= sum_red;
                    if (new_max) begin
                        max_val   <= sum_red;
                        class_idx <= k_q;
                    end
                    bias_q <= bias_q >> W;
                    acc_q  <= acc_q >> ACC_W;
                    k_q    <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer2_bias_argmax.sv
// Scoreboard bench for layer2_bias_argmax: table-driven passes plus start-hold and reset-abort sequences.
module tb_layer2_bias_argmax;

    localparam int OUT_SIZE = 10;
    localparam int W        = 8;
    localparam int ACC_W    = 20;
    localparam int IDX_W    = 4;
    localparam int BW       = OUT_SIZE*W;
    localparam int AW       = OUT_SIZE*ACC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [BW-1:0]     bias_in;
    logic [AW-1:0]     acc_in;
    logic [AW-1:0]     logits_out;
    logic [IDX_W-1:0]  class_idx;
    logic [ACC_W-1:0]  max_val;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    layer2_bias_argmax #(
        .OUT_SIZE(OUT_SIZE), .W(W), .ACC_W(ACC_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .bias_in(bias_in), .acc_in(acc_in),
        .logits_out(logits_out), .class_idx(class_idx), .max_val(max_val),
        .busy(busy), .done(done)
    );

    typedef int arr_t[OUT_SIZE];

    typedef struct {
        logic [BW-1:0]    bias;
        logic [AW-1:0]    acc;
        logic [IDX_W-1:0] exp_idx;
        logic [ACC_W-1:0] exp_max;
    } vec_t;

    typedef struct {
        logic [AW-1:0]    logits;
        logic [IDX_W-1:0] idx;
        logic [ACC_W-1:0] maxv;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [ACC_W-1:0] model_logit(input logic [ACC_W-1:0] a, input logic [W-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef LAYER2_SATURATE_EN
        if (s > (longint'(1) <<< (ACC_W-1)) - 1) s = (longint'(1) <<< (ACC_W-1)) - 1;
        if (s < -(longint'(1) <<< (ACC_W-1)))    s = -(longint'(1) <<< (ACC_W-1));
`endif
        return ACC_W'(s);
    endfunction

    function automatic exp_t model(input vec_t v);
        exp_t             e;
        logic [ACC_W-1:0] l;
        longint           best;
        e.logits = '0;
        e.idx    = '0;
        e.maxv   = '0;
        best     = 0;
        for (int k = 0; k < OUT_SIZE; k++) begin
            l = model_logit(v.acc[k*ACC_W +: ACC_W], v.bias[k*W +: W]);
            e.logits[k*ACC_W +: ACC_W] = l;
            if (k == 0 || longint'($signed(l)) > best) begin
                best   = longint'($signed(l));
                e.idx  = IDX_W'(k);
                e.maxv = l;
            end
        end
        return e;
    endfunction

    function automatic vec_t mk(input arr_t a, input arr_t b, input int idx, input int mx);
        vec_t v;
        for (int k = 0; k < OUT_SIZE; k++) begin
            v.acc[k*ACC_W +: ACC_W] = ACC_W'(a[k]);
            v.bias[k*W +: W]        = W'(b[k]);
        end
        v.exp_idx = IDX_W'(idx);
        v.exp_max = ACC_W'(mx);
        return v;
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard empty at done", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        for (int k = 0; k < OUT_SIZE; k++)
            check($sformatf("logit[%0d]", k), logits_out[k*ACC_W +: ACC_W], e.logits[k*ACC_W +: ACC_W]);
        check("class_idx", class_idx, e.idx);
        check("max_val", max_val, e.maxv);
        last_exp = e;
    endtask

    task automatic scramble();
        bias_in = BW'({$urandom(), $urandom(), $urandom()});
        acc_in  = AW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    task automatic applyStimulus(input vec_t v, input bit extra_start);
        exp_t e;
        int   n;
        bit   busy_ok;
        @(negedge clk);
        bias_in = v.bias;
        acc_in  = v.acc;
        start   = 1'b1;
        e       = model(v);
        e.idx   = v.exp_idx;
        e.maxv  = v.exp_max;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        scramble();
        n       = 1;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            start = (extra_start && n == 3);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("busy during pass", busy_ok, 1);
        check("done latency", n, OUT_SIZE+1);
        if (done) checkOutput();
        else if (sb_q.size() > 0) void'(sb_q.pop_front());
        @(negedge clk);
        check("done single cycle", done, 0);
        check("busy after done", busy, 0);
        check("logits hold", logits_out, last_exp.logits);
    endtask

    initial begin
        vec_t tbl[6];
        arr_t a, b;
        exp_t e;
        int   n;
        bit   seen;

        for (int k = 0; k < OUT_SIZE; k++) begin a[k] = 0; b[k] = k; end
        tbl[0] = mk(a, b, 9, 9);
        for (int k = 0; k < OUT_SIZE; k++) begin a[k] = 0; b[k] = 0; end
        a[2] = 100; a[7] = 100;
        tbl[1] = mk(a, b, 2, 100);
        for (int k = 0; k < OUT_SIZE; k++) begin a[k] = -50; b[k] = -128; end
        b[5] = -3;
        tbl[2] = mk(a, b, 5, -53);
        for (int k = 0; k < OUT_SIZE; k++) begin a[k] = 0; b[k] = 0; end
        a[0] = 524287; b[0] = 127;
`ifdef LAYER2_SATURATE_EN
        tbl[3] = mk(a, b, 0, 524287);
`else
        tbl[3] = mk(a, b, 1, 0);
`endif
        for (int i = 4; i < 6; i++) begin
            for (int k = 0; k < OUT_SIZE; k++) begin
                a[k] = int'($urandom_range(0, 1048575)) - 524288;
                b[k] = int'($urandom_range(0, 255)) - 128;
            end
            tbl[i] = mk(a, b, 0, 0);
            e = model(tbl[i]);
            tbl[i].exp_idx = e.idx;
            tbl[i].exp_max = e.maxv;
        end

        rst = 1'b1; start = 1'b0; bias_in = '0; acc_in = '0;
        repeat (2) @(negedge clk);
        check("reset logits", logits_out, 0);
        check("reset class_idx", class_idx, 0);
        check("reset max_val", max_val, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) applyStimulus(tbl[i], i == 1);

        // start held high: the second pass begins in the IDLE cycle right after done
        @(negedge clk);
        bias_in = tbl[2].bias; acc_in = tbl[2].acc; start = 1'b1;
        e = model(tbl[2]);
        sb_q.push_back(e);
        sb_q.push_back(e);
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 40);
        check("held start first done", n, OUT_SIZE+1);
        if (done) checkOutput();
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 40);
        start = 1'b0;
        check("held start second done", n, OUT_SIZE+2);
        if (done) checkOutput();
        @(negedge clk);
        check("idle after held start", busy, 0);
        sb_q.delete();

        // reset in the middle of a pass, with stray start pulses while busy
        @(negedge clk);
        bias_in = tbl[0].bias; acc_in = tbl[0].acc; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("abort logits", logits_out, 0);
        check("abort class_idx", class_idx, 0);
        check("abort max_val", max_val, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        rst = 1'b0; start = 1'b0;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (done) seen = 1'b1; end
        check("no done after abort", seen, 0);

        applyStimulus(tbl[1], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/layer2_bias_argmax.md
LAYER2_BIAS_ARGMAX -- requirements
Module: layer2_bias_argmax

Interface
REQ-001 Parameter OUT_SIZE, default 10, number of layer-2 output neurons/classes.
REQ-002 Parameter W, default 8, bias width (signed two's complement).
REQ-003 Parameter ACC_W, default 20, accumulator/logit width (signed two's complement).
REQ-004 Parameter IDX_W, default 4, class index width; SHALL satisfy 2^IDX_W >= OUT_SIZE.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin one bias-add/argmax pass; sampled only in IDLE.
REQ-008 bias_in  input  OUT_SIZE*W  flat bias vector from the layer-2 bias loader; element k at [k*W +: W].
REQ-009 acc_in  input  OUT_SIZE*ACC_W  flat layer-2 MAC accumulator vector; element k at [k*ACC_W +: ACC_W].
REQ-010 logits_out  output  OUT_SIZE*ACC_W  biased logits; element k at [k*ACC_W +: ACC_W].
REQ-011 class_idx  output  IDX_W  index of the largest logit.
REQ-012 max_val  output  ACC_W  value of the largest logit.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse when results are valid.

Function
REQ-015 The FSM SHALL have states IDLE, ADD and DONE.
REQ-016 IDLE with start=1 SHALL snapshot bias_in and acc_in into internal registers, clear element counter k to 0, and go to ADD.
REQ-017 Inputs SHALL NOT be read again after the snapshot; changes after the start cycle SHALL have no effect on the pass.
REQ-018 ADD SHALL process exactly one element per cycle, k = 0 to OUT_SIZE-1 in order.
REQ-019 Each logit SHALL be sum_k = acc[k] + sign-extended bias[k], computed at ACC_W+1 bits, then reduced to ACC_W bits per REQ-031/032, and written to logits_out element k in the same cycle.
REQ-020 At k=0, max_val and class_idx SHALL be loaded with sum_0 and 0.
REQ-021 At k>0, they SHALL update only if sum_k > max_val (signed, strictly greater), so ties keep the lowest index.
REQ-022 After element OUT_SIZE-1, the FSM SHALL go to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-024 Latency: with start sampled in cycle T, done SHALL be high in cycle T+OUT_SIZE+1 only.
REQ-025 logits_out, class_idx and max_val SHALL hold their values from DONE until the next pass writes them.
REQ-026 start SHALL be ignored while busy=1; no queuing.
REQ-027 start held high continuously SHALL begin a new pass in the first IDLE cycle after done.

Reset
REQ-028 rst=1 SHALL force IDLE, clear k, and drive logits_out, class_idx, max_val, busy and done to 0 on the next edge.
REQ-029 rst SHALL take priority over start and over any in-progress pass.
REQ-030 A pass aborted by rst SHALL NOT produce a done pulse.

Configuration
REQ-031 With LAYER2_SATURATE_EN defined, a sum outside the signed ACC_W range SHALL clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1); the clamped value SHALL be used for both logits_out and comparison.
REQ-032 Without LAYER2_SATURATE_EN, the sum SHALL be truncated to ACC_W bits (two's-complement wrap); no clamp logic is present.

Verification
REQ-033 acc all 0, bias[k]=k, pulse start at T -> logits k=0..9, class_idx=9, max_val=9, done high only at T+11, busy high T+1..T+11.
REQ-034 acc[2]=acc[7]=100, all others 0, bias all 0 -> class_idx=2, max_val=100.
REQ-035 acc all -50, bias all -128 except bias[5]=-3 -> logit[5]=-53, others -178, class_idx=5, max_val=-53.
REQ-036 acc[0]=524287, bias[0]=127, all others 0 -> with macro: logit[0]=524287, class_idx=0; without macro: logit[0]=-524162, class_idx=1, max_val=0.
REQ-037 start at T, rst at T+5, start pulses during busy -> no done pulse, all outputs 0 at T+6; an extra start while busy in a normal pass leaves done timing unchanged.
